// File: rtl/uart_pkg.sv
// uart_pkg: configuration encodings, default dividers and TX state encoding shared by the UART TX/RX pair.
package uart_pkg;
  localparam int DEF_DIV_4800 = 2604;
  localparam int DEF_DIV_9600 = 1302;
  localparam int DEF_DIV_14K4 = 868;
  localparam int DEF_DIV_19K2 = 651;
  localparam int DEF_OVS = 8;
  localparam int UM_9_BIT = 2;
  localparam int SM_PAR = 1;
  localparam int SM_STOP2 = 0;
  localparam logic [1:0] B_4800 = 2'b00;
  localparam logic [1:0] B_9600 = 2'b01;
  localparam logic [1:0] B_14K4 = 2'b10;
  localparam logic [1:0] B_19K2 = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
  function automatic logic [3:0] data_len(input logic [2:0] u);
    return u[UM_9_BIT] ? 4'd9 : 4'd5 + {1'b0, u};
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud-select divider emitting a one-cycle oversample tick, restartable to phase-align a frame.
module uart_baud_gen import uart_pkg::*; #(
  parameter int DIV_4800 = DEF_DIV_4800,
  parameter int DIV_9600 = DEF_DIV_9600,
  parameter int DIV_14K4 = DEF_DIV_14K4,
  parameter int DIV_19K2 = DEF_DIV_19K2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic [1:0] i_baud,
  output logic       o_tick
);
  logic [15:0] r_cnt;
  logic [15:0] w_div;
  assign w_div = i_baud == B_4800 ? 16'(DIV_4800) :
                 i_baud == B_9600 ? 16'(DIV_9600) :
                 i_baud == B_14K4 ? 16'(DIV_14K4) : 16'(DIV_19K2);
  assign o_tick = r_cnt == w_div - 16'd1;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else r_cnt <= (i_restart || o_tick) ? '0 : r_cnt + 16'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 5-9 data bits, optional even parity, 1/2 stop bits, 8x-oversample bit timing.
module uart_tx import uart_pkg::*; #(
  parameter int DIV_4800 = DEF_DIV_4800,
  parameter int DIV_9600 = DEF_DIV_9600,
  parameter int DIV_14K4 = DEF_DIV_14K4,
  parameter int DIV_19K2 = DEF_DIV_19K2,
  parameter int OVS = DEF_OVS
) (
  input  logic       SCLK,
  input  logic       SCLR,
  input  logic [2:0] UMODE,
  input  logic [1:0] SMODE,
  input  logic [4:0] BMODE,
  input  logic       TX_START,
  input  logic [8:0] TX_DATA,
  output logic       TX,
  output logic       TX_BUSY,
  output logic       TX_DONE
);
  localparam int OW = $clog2(OVS);
  tx_state_t r_state, w_state_nxt;
  logic [8:0] r_shift, w_shift_nxt, w_mask;
  logic [3:0] r_len, r_bit, w_bit_nxt;
  logic [1:0] r_baud;
  logic [OW-1:0] r_ovs;
  logic r_par_en, r_two_stop, r_parity, r_stop, w_stop_nxt, r_tx, w_tx_nxt, r_done, w_done_nxt;
  logic w_tick, w_accept, w_bound, w_unused;
  assign w_unused = &{1'b0, BMODE[2:0]};
  assign w_accept = TX_START && r_state == ST_IDLE;
  assign w_bound = w_tick && r_ovs == OW'(OVS - 1);
  assign w_mask = ~(9'h1FF << data_len(UMODE));
  assign TX = r_tx;
  assign TX_BUSY = r_state != ST_IDLE;
  assign TX_DONE = r_done;
  uart_baud_gen #(
    .DIV_4800(DIV_4800), .DIV_9600(DIV_9600), .DIV_14K4(DIV_14K4), .DIV_19K2(DIV_19K2)
  ) u_baud (
    .i_clk(SCLK), .i_rst(SCLR), .i_restart(w_accept), .i_baud(r_baud), .o_tick(w_tick)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt = r_bit;
    w_stop_nxt = r_stop;
    w_tx_nxt = r_tx;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_START;
        w_shift_nxt = TX_DATA;
        w_bit_nxt = '0;
        w_stop_nxt = 1'b0;
        w_tx_nxt = 1'b0;
      end
      ST_START: if (w_bound) begin
        w_state_nxt = ST_DATA;
        w_tx_nxt = r_shift[0];
      end
      ST_DATA: if (w_bound) begin
        if (r_bit == r_len - 4'd1) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
          w_tx_nxt = r_par_en ? r_parity : 1'b1;
        end else begin
          w_bit_nxt = r_bit + 4'd1;
          w_shift_nxt = r_shift >> 1;
          w_tx_nxt = r_shift[1];
        end
      end
      ST_PARITY: if (w_bound) begin
        w_state_nxt = ST_STOP;
        w_tx_nxt = 1'b1;
      end
      ST_STOP: if (w_bound) begin
        if (r_two_stop && !r_stop) w_stop_nxt = 1'b1;
        else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt = 1'b1;
      end
    endcase
  end
  always_ff @(posedge SCLK or posedge SCLR) begin
    if (SCLR) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit <= '0;
      r_stop <= 1'b0;
      r_tx <= 1'b1;
      r_done <= 1'b0;
      r_ovs <= '0;
      r_len <= '0;
      r_par_en <= 1'b0;
      r_two_stop <= 1'b0;
      r_baud <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit <= w_bit_nxt;
      r_stop <= w_stop_nxt;
      r_tx <= w_tx_nxt;
      r_done <= w_done_nxt;
      r_ovs <= w_accept ? '0 : w_tick ? (r_ovs == OW'(OVS - 1) ? '0 : r_ovs + 1'b1) : r_ovs;
      if (w_accept) begin
        r_len <= data_len(UMODE);
        r_par_en <= SMODE[SM_PAR];
        r_two_stop <= SMODE[SM_STOP2];
        r_baud <= BMODE[4:3];
        r_parity <= ^(TX_DATA & w_mask);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames with hand-computed bit patterns and TX_DONE timing for uart_tx.
module tb_uart_tx;
  logic SCLK = 1'b0, SCLR, TX_START, TX, TX_BUSY, TX_DONE;
  logic [2:0] UMODE;
  logic [1:0] SMODE;
  logic [4:0] BMODE;
  logic [8:0] TX_DATA;
  int err_cnt = 0, chk_cnt = 0;
  uart_tx #(.DIV_4800(4), .DIV_9600(5), .DIV_14K4(6), .DIV_19K2(7), .OVS(8)) dut (
    .SCLK(SCLK), .SCLR(SCLR), .UMODE(UMODE), .SMODE(SMODE), .BMODE(BMODE),
    .TX_START(TX_START), .TX_DATA(TX_DATA), .TX(TX), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
  );
  always #5 SCLK = ~SCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [2:0] u, input logic [1:0] s, input logic [4:0] b, input logic [8:0] d, input logic poke);
    @(negedge SCLK);
    UMODE = u; SMODE = s; BMODE = b; TX_DATA = d; TX_START = 1'b1;
    @(negedge SCLK);
    UMODE = ~u; SMODE = ~s; BMODE = ~b; TX_DATA = ~d; TX_START = poke;
  endtask
  task automatic frame_check(input string tag, input logic [11:0] exp, input int nb, input int p, input logic hold);
    int c;
    check({tag, "_busy"}, TX_BUSY, 1);
    repeat (p / 2) @(negedge SCLK);
    if (!hold) TX_START = 1'b0;
    for (int i = 0; i < nb; i++) begin
      check($sformatf("%s_b%0d", tag, i), TX, exp[i]);
      if (i < nb - 1) repeat (p) @(negedge SCLK);
    end
    c = (nb - 1) * p + p / 2;
    while (!TX_DONE && c < nb * p + 16) begin
      @(negedge SCLK);
      c++;
    end
    check({tag, "_done_at"}, c, nb * p);
    check({tag, "_busy_end"}, TX_BUSY, 0);
    check({tag, "_tx_end"}, TX, 1);
    if (!hold) begin
      @(negedge SCLK);
      check({tag, "_idle_busy"}, TX_BUSY, 0);
      check({tag, "_done_pulse"}, TX_DONE, 0);
    end
  endtask
  initial begin
    int bad;
    SCLR = 1'b1; TX_START = 1'b0; UMODE = '0; SMODE = '0; BMODE = '0; TX_DATA = '0;
    repeat (3) @(negedge SCLK);
    check("rst_tx", TX, 1);
    check("rst_busy", TX_BUSY, 0);
    check("rst_done", TX_DONE, 0);
    SCLR = 1'b0;
    send(3'b110, 2'b00, 5'b01000, 9'h155, 1'b0);
    frame_check("f9", 12'h6AA, 11, 40, 1'b0);
    send(3'b011, 2'b10, 5'b00000, 9'h007, 1'b1);
    frame_check("f8p", 12'h60E, 11, 32, 1'b0);
    send(3'b000, 2'b01, 5'b11000, 9'h01F, 1'b0);
    frame_check("f5s2", 12'h0FE, 8, 56, 1'b0);
    send(3'b000, 2'b10, 5'b10000, 9'h0E3, 1'b0);
    frame_check("f5p", 12'h086, 8, 48, 1'b0);
    @(negedge SCLK);
    UMODE = 3'b000; SMODE = 2'b00; BMODE = 5'b00000; TX_DATA = 9'h015; TX_START = 1'b1;
    @(negedge SCLK);
    UMODE = 3'b001; TX_DATA = 9'h02A;
    frame_check("bbA", 12'h06A, 7, 32, 1'b1);
    @(negedge SCLK);
    frame_check("bbB", 12'h0D4, 8, 32, 1'b0);
    send(3'b011, 2'b00, 5'b00000, 9'h000, 1'b0);
    repeat (48) @(negedge SCLK);
    check("mid_tx", TX, 0);
    SCLR = 1'b1;
    #1;
    check("mid_rst_tx", TX, 1);
    check("mid_rst_busy", TX_BUSY, 0);
    check("mid_rst_done", TX_DONE, 0);
    @(negedge SCLK);
    SCLR = 1'b0;
    bad = 0;
    repeat (400) begin
      @(negedge SCLK);
      if (TX_DONE || !TX || TX_BUSY) bad++;
    end
    check("rst_quiet", bad, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of UART_RX.
- Uses the same UMODE/SMODE/BMODE configuration encoding as UART_RX, so one configuration register drives both ends of a link.
- Serialises a 5–9 bit word with an optional even-parity bit and 1 or 2 stop bits at 4800/9600/14.4k/19.2k baud from a 100 MHz SCLK.

Parameters:
- DIV_4800, 2604, SCLK cycles per 8x-oversample tick at 4800 baud
- DIV_9600, 1302, cycles per tick at 9600 baud
- DIV_14K4, 868, cycles per tick at 14.4k baud
- DIV_19K2, 651, cycles per tick at 19.2k baud
- OVS, 8, oversample ticks per bit (bit period = OVS*DIV cycles)

Ports:
- SCLK  in  1  system clock, rising edge
- SCLR  in  1  reset, asynchronous, active-high
- UMODE  in  3  data length: 000=5, 001=6, 010=7, 011=8, 1xx=9 bits
- SMODE  in  2  [1]=even parity enable, [0]=stop bits (0: one, 1: two)
- BMODE  in  5  [4:3] baud select (00=4800, 01=9600, 10=14.4k, 11=19.2k); [2:0] reserved, ignored
- TX_START  in  1  request; sampled only while TX_BUSY=0
- TX_DATA  in  9  word to send, LSB first; bits above the configured length ignored
- TX  out  1  serial line, idles high
- TX_BUSY  out  1  frame in progress
- TX_DONE  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (async, any state): TX=1, TX_BUSY=0, TX_DONE=0, state=IDLE, all counters 0. Reset mid-frame forces TX=1 immediately; the partial frame is abandoned.
- Accept: on a rising edge with TX_START=1 and TX_BUSY=0, latch TX_DATA, UMODE, SMODE and BMODE[4:3]. Config or data changes mid-frame have no effect. TX_START while busy is ignored (no queueing).
- Latency: on the edge after accept, TX=0 (start bit) and TX_BUSY=1. The tick divider restarts on accept, so the start bit lasts exactly OVS*DIV cycles.
- Bit timing: the tick counter counts 0..DIV-1 and asserts tick at DIV-1. The oversample counter counts ticks 0..OVS-1. A bit boundary occurs on the tick where the oversample count = OVS-1.
- State machine (advances only on bit boundaries):
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA: shifts LSB first for N bits (N from latched UMODE), then goes to PARITY if SMODE[1]=1, else STOP.
  - PARITY -> STOP. Parity bit = XOR of the N data bits (even parity; ones in data+parity is even).
  - STOP: holds TX=1 for 1 or 2 bit periods, then returns to IDLE.
- Frame end: on the cycle STOP exits, TX_DONE=1 for one cycle and TX_BUSY=0 in that same cycle. TX_START asserted in that cycle is accepted (back-to-back frames, no idle gap). TX stays 1.
- TX is registered; it never glitches within a bit period.
- Frame length in bits = 1 + N + P + S; total cycles = that × OVS × DIV.

Decomposition:
- Shared package uart_pkg:
  - UMODE length codes; SMODE bit positions; BMODE baud codes
  - default DIV constants; OVS
  - TX state encoding (IDLE/START/DATA/PARITY/STOP)
- Sub-module uart_baud_gen: BMODE[4:3] -> DIV select, tick counter with synchronous restart input, emits a 1-cycle tick. Shared with UART_RX.

Test Plan (DIV_*=4,5,6,7 overrides; OVS=8):
- Reset mid-frame: assert SCLR during DATA -> TX=1, TX_BUSY=0 within the same cycle, no TX_DONE.
- UMODE=110, SMODE=00, BMODE=01000, TX_DATA=9'h155 -> bit period 40 cycles. TX = 0, 1,0,1,0,1,0,1,0,1, then 1. TX_DONE 440 cycles after the start bit begins.
- UMODE=011, SMODE=10, TX_DATA=8'h07 -> data 1,1,1,0,0,0,0,0, parity 1, one stop bit; 11-bit frame.
- UMODE=000, SMODE=01, BMODE=11000, TX_DATA=5'h1F -> 5 data bits of 1, two stop bits, bit period 56 cycles. TX_DATA[8:5] has no effect.
- TX_START held high continuously for two frames -> second start bit begins the cycle after the TX_DONE pulse. The UMODE change issued mid-frame applies only to the second frame.
- Loopback with UART_RX under identical config and random data across all modes -> RX_DATA matches and RX_ERR=0.
